// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters (master) and the 4-way round-robin arbiter (slave).
interface rr_arbiter4_if;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic       timeout;

   modport master (output req, output done, input gnt, input gnt_valid, input timeout);
   modport slave  (input req, input done, output gnt, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with done/req-drop release and a bounded hold time.
module rr_arbiter4 #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   rr_arbiter4_if.slave   bus
);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   localparam int unsigned CNT_W     = 8;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [0:0]       state, state_nxt;
   logic [1:0]       ptr, ptr_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [3:0]       gnt_nxt;
   logic             gnt_valid_nxt;
   logic             timeout_nxt;

   logic [7:0]       req_dbl;
   logic [3:0]       req_rot;
   logic [1:0]       win_off;
   logic [1:0]       win_idx;
   logic             win_valid;
   logic             owner_req;
   logic             hold_hit;
   logic             early_rel;

   // Rotate requests so that bit 0 is the requester at ptr, then pick the lowest set bit.
   assign req_dbl   = {bus.req, bus.req};
   assign req_rot   = 4'(req_dbl >> ptr);
   assign win_valid = |bus.req;
   assign win_idx   = 2'(ptr + win_off);

   always_comb begin
      win_off = 2'd0;
      casez (req_rot)
         4'b???1: win_off = 2'd0;
         4'b??10: win_off = 2'd1;
         4'b?100: win_off = 2'd2;
         4'b1000: win_off = 2'd3;
         default: win_off = 2'd0;
      endcase
   end

   assign owner_req = |(bus.req & bus.gnt);
   assign hold_hit  = (hold_cnt == HOLD_LAST);
   assign early_rel = bus.done | ~owner_req;

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      hold_cnt_nxt  = hold_cnt;
      gnt_nxt       = bus.gnt;
      timeout_nxt   = 1'b0;

      case (state)
         IDLE: begin
            gnt_nxt = 4'b0000;
            if (win_valid) begin
               state_nxt    = GRANT;
               gnt_nxt      = 4'b0001 << win_idx;
               ptr_nxt      = 2'(win_idx + 2'd1);
               hold_cnt_nxt = '0;
            end
         end
         GRANT: begin
            if (early_rel || hold_hit) begin
               state_nxt   = IDLE;
               gnt_nxt     = 4'b0000;
               timeout_nxt = hold_hit & ~early_rel;
            end else begin
               hold_cnt_nxt = CNT_W'(hold_cnt + 1'b1);
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
         end
      endcase

      gnt_valid_nxt = |gnt_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= 2'd0;
         hold_cnt      <= '0;
         bus.gnt       <= 4'b0000;
         bus.gnt_valid <= 1'b0;
         bus.timeout   <= 1'b0;
      end else begin
         state         <= state_nxt;
         ptr           <= ptr_nxt;
         hold_cnt      <= hold_cnt_nxt;
         bus.gnt       <= gnt_nxt;
         bus.gnt_valid <= gnt_valid_nxt;
         bus.timeout   <= timeout_nxt;
      end
   end
endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 (MAX_HOLD = 4) with hand-computed grant sequences.
module tb_rr_arbiter4;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   rr_arbiter4_if arb_if ();

   rr_arbiter4 #(.MAX_HOLD(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (arb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream 4:2 encoder driven by gnt.
   function automatic logic [1:0] encoder4_2(input logic [3:0] g);
      return {g[3] | g[2], g[3] | g[1]};
   endfunction

   function automatic logic [1:0] one_hot_idx(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
      return r;
   endfunction

   task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check(input string tag, input logic [3:0] exp_gnt, input logic exp_to);
      chk4({tag, ".gnt"}, arb_if.gnt, exp_gnt);
      chk1({tag, ".gnt_valid"}, arb_if.gnt_valid, |exp_gnt);
      chk1({tag, ".timeout"}, arb_if.timeout, exp_to);
      if (exp_gnt != 4'b0000) begin
         n_cmp++;
         assert (encoder4_2(arb_if.gnt) === one_hot_idx(exp_gnt)) else begin
            n_bad++;
            $error("FAIL %s.enc: observed %0d expected %0d", tag,
                   encoder4_2(arb_if.gnt), one_hot_idx(exp_gnt));
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n       = 1'b0;
      arb_if.req  = 4'b0000;
      arb_if.done = 1'b0;
      #1;
      check("reset", 4'b0000, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Grant seen, hold one more cycle, pulse done, see the gap, then see the next grant.
   task automatic grant_with_done(input string tag, input logic [3:0] cur, input logic [3:0] nxt);
      step();
      check({tag, ".hold"}, cur, 1'b0);
      arb_if.done = 1'b1;
      step();
      check({tag, ".gap"}, 4'b0000, 1'b0);
      arb_if.done = 1'b0;
      step();
      check({tag, ".next"}, nxt, 1'b0);
   endtask

   // Invariants sampled every cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         n_cmp++;
         assert ($onehot0(arb_if.gnt)) else begin
            n_bad++;
            $error("FAIL onehot: observed %b expected one-hot or zero", arb_if.gnt);
         end
         n_cmp++;
         assert (arb_if.gnt_valid === (|arb_if.gnt)) else begin
            n_bad++;
            $error("FAIL gnt_valid_or: observed %b expected %b", arb_if.gnt_valid, |arb_if.gnt);
         end
      end
   end

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      rst_n       = 1'b0;
      arb_if.req  = 4'b0000;
      arb_if.done = 1'b0;
      #12;
      check("por", 4'b0000, 1'b0);

      // Round-robin rotation with all requesters active.
      do_reset();
      arb_if.req = 4'b1111;
      step();
      check("rr.g0", 4'b0001, 1'b0);
      grant_with_done("rr.a", 4'b0001, 4'b0010);
      grant_with_done("rr.b", 4'b0010, 4'b0100);
      grant_with_done("rr.c", 4'b0100, 4'b1000);
      grant_with_done("rr.d", 4'b1000, 4'b0001);
      arb_if.req = 4'b0000;
      step();
      check("rr.drop", 4'b0000, 1'b0);
      step();
      check("rr.idle", 4'b0000, 1'b0);

      // Pointer wrap 3 -> 0 -> 1.
      do_reset();
      arb_if.req = 4'b0100;
      step();
      check("wrap.g2", 4'b0100, 1'b0);
      arb_if.req = 4'b0001;
      step();
      check("wrap.rel", 4'b0000, 1'b0);
      step();
      check("wrap.g0", 4'b0001, 1'b0);
      arb_if.req = 4'b1111;
      step();
      check("wrap.nochange", 4'b0001, 1'b0);
      arb_if.done = 1'b1;
      step();
      check("wrap.done", 4'b0000, 1'b0);
      arb_if.done = 1'b0;
      step();
      check("wrap.ptr1", 4'b0010, 1'b0);
      arb_if.req = 4'b0000;
      step();
      check("wrap.end", 4'b0000, 1'b0);
      arb_if.done = 1'b1;
      step();
      check("idle.done", 4'b0000, 1'b0);
      arb_if.done = 1'b0;

      // Forced release after MAX_HOLD cycles.
      do_reset();
      arb_if.req = 4'b0010;
      step();
      check("to.h0", 4'b0010, 1'b0);
      step();
      check("to.h1", 4'b0010, 1'b0);
      step();
      check("to.h2", 4'b0010, 1'b0);
      step();
      check("to.h3", 4'b0010, 1'b0);
      step();
      check("to.pulse", 4'b0000, 1'b1);
      step();
      check("to.regrant", 4'b0010, 1'b0);
      step();
      step();
      step();
      check("to.last", 4'b0010, 1'b0);
      arb_if.done = 1'b1;
      step();
      check("to.coincide", 4'b0000, 1'b0);
      arb_if.done = 1'b0;
      arb_if.req  = 4'b0000;
      step();
      check("to.end", 4'b0000, 1'b0);

      // Owner drops its request while others wait.
      do_reset();
      arb_if.req = 4'b0001;
      step();
      check("drop.g0", 4'b0001, 1'b0);
      arb_if.req = 4'b1110;
      step();
      check("drop.rel", 4'b0000, 1'b0);
      step();
      check("drop.g1", 4'b0010, 1'b0);
      arb_if.req = 4'b0000;
      step();

      // Asynchronous reset mid-grant.
      do_reset();
      arb_if.req = 4'b1000;
      step();
      check("ar.g3", 4'b1000, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check("ar.async", 4'b0000, 1'b0);
      arb_if.req = 4'b1001;
      #3;
      rst_n = 1'b1;
      step();
      check("ar.g0", 4'b0001, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 15: maximum number of cycles one grant may be held before forced release; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request lines; bit k set means requester k wants the resource.
REQ-005 done  input  1  release pulse from the current owner; ignored when no grant is active.
REQ-006 gnt  output  4  registered grant, one-hot or all-zero; drives the downstream 4:2 encoder input directly.
REQ-007 gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-008 timeout  output  1  registered one-cycle pulse on a forced release.

Function
REQ-009 The FSM SHALL have two states, IDLE and GRANT, held in registers.
REQ-010 In IDLE with req != 0: on the next edge, go to GRANT and set gnt to the one-hot bit of the first set req bit, searching upward from ptr modulo 4 (priority ptr, ptr+1, ptr+2, ptr+3).
REQ-011 In IDLE with req == 0: remain in IDLE with gnt = 0.
REQ-012 Grant latency SHALL be exactly one cycle from req sampled in IDLE to gnt asserted.
REQ-013 ptr SHALL be a 2-bit register loaded with (winner index + 1) mod 4 on every grant; 3+1 wraps to 0.
REQ-014 In GRANT, gnt SHALL hold constant until a release event.
REQ-015 Release events: (a) done = 1; (b) the granted requester's req bit = 0; (c) hold counter reaches MAX_HOLD-1.
REQ-016 On any release event, the next edge SHALL clear gnt and return to IDLE; re-arbitration occurs one cycle later, so there is always at least one gnt = 0 cycle between grants.
REQ-017 The hold counter (8-bit) SHALL clear on entry to GRANT, increment each GRANT cycle, and saturate at no value other than MAX_HOLD-1.
REQ-018 timeout SHALL pulse high for one cycle, coincident with gnt clearing, only when release is caused by (c) and neither (a) nor (b) is true in the same cycle.
REQ-019 When release conditions occur simultaneously, the block SHALL perform one release only; timeout behaviour follows REQ-018.
REQ-020 Requests arriving during GRANT SHALL NOT change gnt; they are served through normal IDLE arbitration.
REQ-021 gnt SHALL never have more than one bit set in any cycle, including the cycle after reset deassertion.
REQ-022 done asserted in IDLE SHALL have no effect.

Reset
REQ-023 While rst_n = 0, asynchronously: state = IDLE, gnt = 0000, gnt_valid = 0, timeout = 0, ptr = 0, hold counter = 0.
REQ-024 Reset asserted mid-grant SHALL clear gnt immediately without waiting for a clock edge; after reset is released, arbitration restarts with priority to requester 0.
REQ-025 The first arbitration SHALL occur on the first rising edge after rst_n rises with req != 0.

Verification
REQ-026 Reset, then req = 1111 held with a done pulse 2 cycles after each grant -> gnt sequence 0001, 0010, 0100, 1000, 0001, with one zero cycle between each grant.
REQ-027 From reset, req = 0100 -> gnt = 0100 one cycle later; then req = 0001 -> gnt = 0001 next grant, and ptr wraps to 1.
REQ-028 MAX_HOLD = 4, req = 0010 held, done never asserted -> gnt = 0010 for 4 cycles, then gnt = 0000 with timeout = 1 for one cycle, then re-grant of 0010.
REQ-029 During a 0001 grant, drop req[0] while req = 1110 -> gnt clears next edge and timeout = 0; the next grant is 0010.
REQ-030 Assert rst_n = 0 mid-cycle during a 1000 grant -> gnt = 0000 immediately; after reset, with req = 1001, the next grant is 0001.
REQ-031 Throughout all scenarios, check that gnt is one-hot or zero and that gnt_valid equals the OR of the gnt bits; feed gnt into encoder4_2 and verify the encoded output matches the winner index.
